lsu_wb_stage: RTL and testbench

Load/store unit sitting directly upstream of the register file write port. It takes one memory request from the decode/execute stage, drives a byte-enabled data-memory bus with a ready handshake, and extracts and extends load data. It then produces the register file write triple (wb_wa, wb_we, wb_wd) for exactly one cycle. While an access is outstanding it stalls the core.

---
 rtl/lsu_pkg.sv | 21 ++
 rtl/lsu_data_align.sv | 63 ++++++
 rtl/lsu_wb_stage.sv | 186 ++++++++++++++++++
 tb/tb_lsu_wb_stage.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
// Access sizes, FSM states and counter sizing.
package lsu_pkg;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_DONE
    } state_t;

    function automatic int cnt_width(input int t);
        return $clog2(t + 1);
    endfunction

endpackage

// File: rtl/lsu_data_align.sv
// Lane steering for the load/store unit.
// Byte enables, store replication, load extraction and legality flags.
module lsu_data_align
    import lsu_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  size,
    input  logic [1:0]  addr,
    input  logic [31:0] wd,
    input  logic [31:0] rd,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        misalign,
    output logic        illegal
);

    logic [7:0]  bt;
    logic [15:0] hw;

    assign bt = rd[{addr, 3'b000} +: 8];
    assign hw = rd[{addr[1], 4'b0000} +: 16];

    always_comb begin
        be       = '0;
        wdata    = '0;
        rdata    = '0;
        misalign = 1'b0;
        illegal  = 1'b0;
        unique case (size)
            SZ_B: begin
                be    = 4'b0001 << addr;
                wdata = {4{wd[7:0]}};
                rdata = {{24{bt[7]}}, bt};
            end
            SZ_BU: begin
                be      = 4'b0001 << addr;
                rdata   = {24'h0, bt};
                illegal = we;
            end
            SZ_H: begin
                be       = addr[1] ? 4'b1100 : 4'b0011;
                wdata    = {2{wd[15:0]}};
                rdata    = {{16{hw[15]}}, hw};
                misalign = addr[0];
            end
            SZ_HU: begin
                be       = addr[1] ? 4'b1100 : 4'b0011;
                rdata    = {16'h0, hw};
                misalign = addr[0];
                illegal  = we;
            end
            SZ_W: begin
                be       = 4'b1111;
                wdata    = wd;
                rdata    = rd;
                misalign = |addr;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/lsu_wb_stage.sv
// Load/store unit: bus handshake FSM with timeout and a
// one-cycle register file writeback on completion.
module lsu_wb_stage
    import lsu_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 16,
    parameter logic [31:0] RESET_ADDR_VAL = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        lsu_req,
    input  logic        lsu_we,
    input  logic [2:0]  lsu_size,
    input  logic [31:0] lsu_addr,
    input  logic [31:0] lsu_wd,
    input  logic [4:0]  lsu_wa,
    output logic        lsu_stall,
    output logic        lsu_done,
    output logic        lsu_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd,
    input  logic        mem_ready,
    output logic [4:0]  wb_wa,
    output logic        wb_we,
    output logic [31:0] wb_wd
);

    localparam int CW = cnt_width(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [2:0]    size_q, size_d;
    logic [1:0]    addr_q, addr_d;
    logic [4:0]    wa_q, wa_d;

    logic        req_d, mwe_d, done_d, err_d, wbwe_d;
    logic [3:0]  be_d;
    logic [31:0] maddr_d, mwd_d, wbwd_d;
    logic [4:0]  wbwa_d;

    logic        idle;
    logic        a_we;
    logic [2:0]  a_size;
    logic [1:0]  a_addr;
    logic [3:0]  a_be;
    logic [31:0] a_wdata, a_rdata;
    logic        a_mis, a_ill;

    // In IDLE the request is checked straight off the inputs;
    // afterwards the latched copy drives load extraction.
    assign idle   = (state_q == ST_IDLE);
    assign a_we   = idle ? lsu_we : we_q;
    assign a_size = idle ? lsu_size : size_q;
    assign a_addr = idle ? lsu_addr[1:0] : addr_q;

    lsu_data_align u_align (
        .we       (a_we),
        .size     (a_size),
        .addr     (a_addr),
        .wd       (lsu_wd),
        .rd       (mem_rd),
        .be       (a_be),
        .wdata    (a_wdata),
        .rdata    (a_rdata),
        .misalign (a_mis),
        .illegal  (a_ill)
    );

    assign lsu_stall = lsu_req & ~lsu_done;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        size_d  = size_q;
        addr_d  = addr_q;
        wa_d    = wa_q;
        req_d   = 1'b0;
        mwe_d   = 1'b0;
        be_d    = '0;
        maddr_d = RESET_ADDR_VAL;
        mwd_d   = '0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        wbwe_d  = 1'b0;
        wbwa_d  = '0;
        wbwd_d  = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (lsu_req) begin
                    we_d   = lsu_we;
                    size_d = lsu_size;
                    addr_d = lsu_addr[1:0];
                    wa_d   = lsu_wa;
                    cnt_d  = '0;
                    if (a_mis || a_ill) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        wbwa_d  = lsu_wa;
                    end else begin
                        state_d = ST_ACCESS;
                        req_d   = 1'b1;
                        mwe_d   = lsu_we;
                        be_d    = a_be;
                        maddr_d = {lsu_addr[31:2], 2'b00};
                        mwd_d   = lsu_we ? a_wdata : 32'h0;
                    end
                end
            end
            ST_ACCESS: begin
                if (mem_ready) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    wbwa_d  = wa_q;
                    wbwe_d  = ~we_q & (wa_q != 5'd0);
                    wbwd_d  = we_q ? 32'h0 : a_rdata;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                    wbwa_d  = wa_q;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    req_d   = mem_req;
                    mwe_d   = mem_we;
                    be_d    = mem_be;
                    maddr_d = mem_addr;
                    mwd_d   = mem_wd;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            we_q     <= 1'b0;
            size_q   <= '0;
            addr_q   <= '0;
            wa_q     <= '0;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            mem_be   <= '0;
            mem_addr <= RESET_ADDR_VAL;
            mem_wd   <= '0;
            lsu_done <= 1'b0;
            lsu_err  <= 1'b0;
            wb_we    <= 1'b0;
            wb_wa    <= '0;
            wb_wd    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            we_q     <= we_d;
            size_q   <= size_d;
            addr_q   <= addr_d;
            wa_q     <= wa_d;
            mem_req  <= req_d;
            mem_we   <= mwe_d;
            mem_be   <= be_d;
            mem_addr <= maddr_d;
            mem_wd   <= mwd_d;
            lsu_done <= done_d;
            lsu_err  <= err_d;
            wb_we    <= wbwe_d;
            wb_wa    <= wbwa_d;
            wb_wd    <= wbwd_d;
        end
    end

endmodule

// File: tb/tb_lsu_wb_stage.sv
// Scoreboard bench for lsu_wb_stage: load/store/error/timeout,
// mid-access reset and back-to-back requests.
module tb_lsu_wb_stage;

    localparam int          T   = 16;
    localparam logic [31:0] RST = 32'h0000_0F00;

    logic        clk, rst_n;
    logic        lsu_req, lsu_we;
    logic [2:0]  lsu_size;
    logic [31:0] lsu_addr, lsu_wd;
    logic [4:0]  lsu_wa;
    logic        lsu_stall, lsu_done, lsu_err;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wd, mem_rd;
    logic        mem_ready;
    logic [4:0]  wb_wa;
    logic        wb_we;
    logic [31:0] wb_wd;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        err;
        logic        wbwe;
        logic [4:0]  wa;
        logic [31:0] wd;
    } exp_t;

    exp_t sb[$];

    lsu_wb_stage #(
        .TIMEOUT_CYCLES (T),
        .RESET_ADDR_VAL (RST)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .lsu_req   (lsu_req),
        .lsu_we    (lsu_we),
        .lsu_size  (lsu_size),
        .lsu_addr  (lsu_addr),
        .lsu_wd    (lsu_wd),
        .lsu_wa    (lsu_wa),
        .lsu_stall (lsu_stall),
        .lsu_done  (lsu_done),
        .lsu_err   (lsu_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wd    (mem_wd),
        .mem_rd    (mem_rd),
        .mem_ready (mem_ready),
        .wb_wa     (wb_wa),
        .wb_we     (wb_we),
        .wb_wd     (wb_wd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_cycle();
        lsu_req   = 1'b0;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if ({lsu_done, wb_we, mem_req} !== 3'b000 || mem_addr !== RST) begin
            n_fail++;
            $display("FAIL idle done/we/req=%b addr=%h exp 000 %h",
                     {lsu_done, wb_we, mem_req}, mem_addr, RST);
        end
    endtask

    task automatic do_access(
        input logic        we,
        input logic [2:0]  size,
        input logic [31:0] addr,
        input logic [31:0] wd,
        input logic [4:0]  wa,
        input logic [31:0] rd,
        input int          lat,
        input logic [3:0]  ebe,
        input logic [31:0] ewd,
        input logic        eerr,
        input logic        ewbwe,
        input logic [31:0] ewbwd,
        input int          edges,
        input int          estall,
        input int          ereq,
        input string       nm
    );
        exp_t e, g;
        int k, n, stall;
        logic seen;
        e.err = eerr; e.wbwe = ewbwe; e.wa = wa; e.wd = ewbwd;
        sb.push_back(e);
        lsu_req = 1'b1; lsu_we = we; lsu_size = size;
        lsu_addr = addr; lsu_wd = wd; lsu_wa = wa;
        #1;
        stall = lsu_stall ? 1 : 0;
        k = 0; n = 0; seen = 1'b0;
        for (int c = 0; c < 60 && !seen; c++) begin
            @(posedge clk);
            #1;
            n++;
            if (lsu_done) begin
                seen = 1'b1;
                g = sb.pop_front();
                n_checks++;
                if (lsu_err !== g.err || wb_we !== g.wbwe) begin
                    n_fail++;
                    $display("FAIL %s err/wb_we got %b%b exp %b%b",
                             nm, lsu_err, wb_we, g.err, g.wbwe);
                end
                if (g.wbwe) begin
                    n_checks++;
                    if (wb_wa !== g.wa || wb_wd !== g.wd) begin
                        n_fail++;
                        $display("FAIL %s wb got %0d/%h exp %0d/%h",
                                 nm, wb_wa, wb_wd, g.wa, g.wd);
                    end
                end
                lsu_req   = 1'b0;
                mem_ready = 1'b0;
            end else begin
                if (lsu_stall) stall++;
                if (mem_req) begin
                    if (k == 0) begin
                        n_checks++;
                        if (mem_we !== we || mem_be !== ebe ||
                            mem_addr !== {addr[31:2], 2'b00} ||
                            mem_wd !== ewd) begin
                            n_fail++;
                            $display("FAIL %s bus got we=%b be=%b a=%h d=%h exp %b %b %h %h",
                                     nm, mem_we, mem_be, mem_addr, mem_wd,
                                     we, ebe, {addr[31:2], 2'b00}, ewd);
                        end
                    end
                    mem_ready = (lat >= 0 && k == lat);
                    mem_rd    = rd;
                    k++;
                end else begin
                    mem_ready = 1'b0;
                end
            end
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            void'(sb.pop_front());
            lsu_req = 1'b0;
            mem_ready = 1'b0;
            $display("FAIL %s no lsu_done within 60 cycles", nm);
        end else if (n != edges || stall != estall || k != ereq) begin
            n_fail++;
            $display("FAIL %s cycles/stall/req got %0d/%0d/%0d exp %0d/%0d/%0d",
                     nm, n, stall, k, edges, estall, ereq);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; lsu_req = 1'b0; lsu_we = 1'b0; lsu_size = '0;
        lsu_addr = '0; lsu_wd = '0; lsu_wa = '0;
        mem_rd = '0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({lsu_done, lsu_err, mem_req, mem_we, wb_we} !== 5'b0 ||
            mem_be !== 4'h0 || mem_wd !== 32'h0 || mem_addr !== RST ||
            wb_wa !== 5'd0 || wb_wd !== 32'h0 || lsu_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL reset flags=%b be=%b addr=%h exp 0 0 %h",
                     {lsu_done, lsu_err, mem_req, mem_we, wb_we},
                     mem_be, mem_addr, RST);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_loads();
        idle_cycle();
        do_access(0, 3'b010, 32'h100, 0, 5, 32'hDEAD_BEEF, 0, 4'b1111, 0,
                  0, 1, 32'hDEAD_BEEF, 2, 2, 1, "lw");
        idle_cycle();
        do_access(0, 3'b000, 32'h103, 0, 7, 32'h80FF_0000, 0, 4'b1000, 0,
                  0, 1, 32'hFFFF_FF80, 2, 2, 1, "lb");
        idle_cycle();
        do_access(0, 3'b100, 32'h103, 0, 7, 32'h80FF_0000, 0, 4'b1000, 0,
                  0, 1, 32'h0000_0080, 2, 2, 1, "lbu");
        idle_cycle();
        do_access(0, 3'b101, 32'h102, 0, 9, 32'h80FF_0000, 0, 4'b1100, 0,
                  0, 1, 32'h0000_80FF, 2, 2, 1, "lhu");
        idle_cycle();
        do_access(0, 3'b001, 32'h102, 0, 9, 32'h80FF_0000, 0, 4'b1100, 0,
                  0, 1, 32'hFFFF_80FF, 2, 2, 1, "lh");
        idle_cycle();
        do_access(0, 3'b000, 32'h104, 0, 0, 32'h0000_0055, 0, 4'b0001, 0,
                  0, 0, 32'h0, 2, 2, 1, "lb_x0");
        idle_cycle();
        do_access(0, 3'b010, 32'h20C, 0, 3, 32'h1357_9BDF, 3, 4'b1111, 0,
                  0, 1, 32'h1357_9BDF, 5, 5, 4, "lw_lat3");
    endtask

    task automatic test_stores();
        idle_cycle();
        do_access(1, 3'b000, 32'h201, 32'h1234_56AB, 4, 0, 0, 4'b0010,
                  32'hABAB_ABAB, 0, 0, 0, 2, 2, 1, "sb");
        idle_cycle();
        do_access(1, 3'b001, 32'h202, 32'h0000_BEEF, 4, 0, 1, 4'b1100,
                  32'hBEEF_BEEF, 0, 0, 0, 3, 3, 2, "sh");
        idle_cycle();
        do_access(1, 3'b010, 32'h300, 32'hCAFE_F00D, 4, 0, 0, 4'b1111,
                  32'hCAFE_F00D, 0, 0, 0, 2, 2, 1, "sw");
    endtask

    task automatic test_errors();
        idle_cycle();
        do_access(0, 3'b010, 32'h102, 0, 6, 0, 0, 0, 0,
                  1, 0, 0, 1, 1, 0, "lw_misalign");
        idle_cycle();
        do_access(0, 3'b001, 32'h101, 0, 6, 0, 0, 0, 0,
                  1, 0, 0, 1, 1, 0, "lh_misalign");
        idle_cycle();
        do_access(1, 3'b100, 32'h100, 32'h1, 6, 0, 0, 0, 0,
                  1, 0, 0, 1, 1, 0, "sbu_illegal");
        idle_cycle();
        do_access(0, 3'b011, 32'h100, 0, 6, 0, 0, 0, 0,
                  1, 0, 0, 1, 1, 0, "ld_illegal");
    endtask

    task automatic test_timeout();
        idle_cycle();
        do_access(0, 3'b010, 32'h400, 0, 8, 32'h1111_2222, -1, 4'b1111, 0,
                  1, 0, 0, T + 1, T + 1, T, "timeout");
        idle_cycle();
        do_access(0, 3'b010, 32'h404, 0, 8, 32'h3333_4444, T - 1, 4'b1111, 0,
                  0, 1, 32'h3333_4444, T + 1, T + 1, T, "ready_last");
    endtask

    task automatic test_mid_reset();
        logic bad;
        idle_cycle();
        lsu_req = 1'b1; lsu_we = 1'b0; lsu_size = 3'b010;
        lsu_addr = 32'h500; lsu_wa = 5'd2; mem_ready = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (mem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst accept mem_req=%b exp 1", mem_req);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (mem_req !== 1'b0 || lsu_done !== 1'b0 || mem_addr !== RST) begin
            n_fail++;
            $display("FAIL midrst req=%b done=%b addr=%h exp 0 0 %h",
                     mem_req, lsu_done, mem_addr, RST);
        end
        rst_n = 1'b1;
        lsu_req = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (lsu_done !== 1'b0 || mem_req !== 1'b0 || wb_we !== 1'b0)
                bad = 1'b1;
        end
        n_checks++;
        if (bad !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_after spurious activity got %b exp 0", bad);
        end
        do_access(0, 3'b010, 32'h504, 0, 2, 32'h0BAD_F00D, 0, 4'b1111, 0,
                  0, 1, 32'h0BAD_F00D, 2, 2, 1, "post_rst");
    endtask

    task automatic test_back_to_back();
        idle_cycle();
        do_access(0, 3'b010, 32'h600, 0, 10, 32'hAAAA_5555, 0, 4'b1111, 0,
                  0, 1, 32'hAAAA_5555, 2, 2, 1, "b2b_1");
        do_access(0, 3'b000, 32'h602, 0, 11, 32'h0071_0000, 0, 4'b0100, 0,
                  0, 1, 32'h0000_0071, 3, 2, 1, "b2b_2");
        idle_cycle();
    endtask

    initial begin
        test_reset();
        test_loads();
        test_stores();
        test_errors();
        test_timeout();
        test_mid_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
